// File: rtl/stack_pkg.sv
// Shared stack operation encodings and error codes, reused by the instruction decoders.
package stack_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CODE_W = 8;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_PUSH  = 3'd1;
  localparam logic [OP_W-1:0] OP_POP   = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL  = 3'd3;
  localparam logic [OP_W-1:0] OP_RET   = 3'd4;
  localparam logic [OP_W-1:0] OP_FLUSH = 3'd5;

  localparam logic [CODE_W-1:0] ERR_NONE      = 8'h00;
  localparam logic [CODE_W-1:0] ERR_PUSH_FULL = 8'h03;
  localparam logic [CODE_W-1:0] ERR_POP_EMPTY = 8'h04;
  localparam logic [CODE_W-1:0] ERR_RET_EMPTY = 8'h05;
  localparam logic [CODE_W-1:0] ERR_CALL_FULL = 8'h06;
  localparam logic [CODE_W-1:0] ERR_RSVD_OP   = 8'h07;

endpackage

// File: rtl/stack_ctrl.sv
// Downward-growing hardware stack controller: address generation, occupancy,
// high-water mark and sticky error reporting for PUSH/POP/CALL/RET/FLUSH.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned    DEPTH = 7,
  parameter int unsigned    AW    = 16,
  parameter logic [AW-1:0]  TOP   = AW'(16'h00FF),
  localparam int unsigned   CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op,
  input  logic              err_clr,
  input  logic [AW-1:0]     ret_in,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              pc_load,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     hwm,
  output logic              err,
  output logic [CODE_W-1:0] err_code
);

  logic [CW-1:0]     count_q, count_nxt;
  logic [CW-1:0]     hwm_q, hwm_nxt;
  logic              err_q, err_nxt;
  logic [CODE_W-1:0] code_q, code_nxt;

  logic              is_inc, is_dec, is_ret, is_flush;
  logic [CODE_W-1:0] bad_code;
  logic              acc_inc, acc_dec;
  logic [AW-1:0]     count_ext;

  // ret_in feeds the write-data mux outside this block; only the select is produced here
  logic unused_ret;
  assign unused_ret = ^ret_in;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count_ext = AW'(count_q);

  // Op decode and error classification
  always_comb begin
    is_inc   = 1'b0;
    is_dec   = 1'b0;
    is_ret   = 1'b0;
    is_flush = 1'b0;
    bad_code = ERR_NONE;
    if (op_valid) begin
      case (op)
        OP_NOP: ;
        OP_PUSH: begin
          is_inc = 1'b1;
          if (full) bad_code = ERR_PUSH_FULL;
        end
        OP_POP: begin
          is_dec = 1'b1;
          if (empty) bad_code = ERR_POP_EMPTY;
        end
        OP_CALL: begin
          is_inc = 1'b1;
          if (full) bad_code = ERR_CALL_FULL;
        end
        OP_RET: begin
          is_dec = 1'b1;
          is_ret = 1'b1;
          if (empty) bad_code = ERR_RET_EMPTY;
        end
        OP_FLUSH: is_flush = 1'b1;
        default:  bad_code = ERR_RSVD_OP;
      endcase
    end
  end

  assign acc_inc = is_inc && (bad_code == ERR_NONE);
  assign acc_dec = is_dec && (bad_code == ERR_NONE);

  // Strobes are forced low while reset is asserted
  assign mem_we  = acc_inc && rst_n;
  assign mem_re  = acc_dec && rst_n;
  assign pc_load = acc_dec && is_ret && rst_n;

  always_comb begin
    mem_addr = '1;
    if (is_inc)      mem_addr = TOP - count_ext;
    else if (is_dec) mem_addr = TOP + AW'(1) - count_ext;
  end

  // Next-state for occupancy, high-water mark and sticky error
  always_comb begin
    count_nxt = count_q;
    hwm_nxt   = hwm_q;
    err_nxt   = err_q;
    code_nxt  = code_q;

    if (is_flush)     count_nxt = '0;
    else if (acc_inc) count_nxt = count_q + CW'(1);
    else if (acc_dec) count_nxt = count_q - CW'(1);

    if (is_flush)               hwm_nxt = '0;
    else if (count_nxt > hwm_q) hwm_nxt = count_nxt;

    if (bad_code != ERR_NONE) begin
      err_nxt = 1'b1;
      if (!err_q || err_clr) code_nxt = bad_code;
    end else if (err_clr) begin
      err_nxt  = 1'b0;
      code_nxt = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hwm_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      count_q <= count_nxt;
      hwm_q   <= hwm_nxt;
      err_q   <= err_nxt;
      code_q  <= code_nxt;
    end
  end

  assign count    = count_q;
  assign hwm      = hwm_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios plus randomized ops on a
// default instance and a small (DEPTH=3, AW=8, TOP=0x02) instance, against a stack model.
module tb_stack_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // default instance
  logic        m_valid, m_clr;
  logic [2:0]  m_op;
  logic [15:0] m_ret, m_addr;
  logic        m_we, m_re, m_pcl, m_full, m_empty, m_err;
  logic [2:0]  m_count, m_hwm;
  logic [7:0]  m_code;

  // small instance
  logic        s_valid, s_clr;
  logic [2:0]  s_op;
  logic [7:0]  s_ret, s_addr;
  logic        s_we, s_re, s_pcl, s_full, s_empty, s_err;
  logic [1:0]  s_count, s_hwm;
  logic [7:0]  s_code;

  stack_ctrl u_main (
    .clk(clk), .rst_n(rst_n), .op_valid(m_valid), .op(m_op), .err_clr(m_clr),
    .ret_in(m_ret), .mem_addr(m_addr), .mem_we(m_we), .mem_re(m_re),
    .pc_load(m_pcl), .count(m_count), .full(m_full), .empty(m_empty),
    .hwm(m_hwm), .err(m_err), .err_code(m_code)
  );

  stack_ctrl #(.DEPTH(3), .AW(8), .TOP(8'h02)) u_small (
    .clk(clk), .rst_n(rst_n), .op_valid(s_valid), .op(s_op), .err_clr(s_clr),
    .ret_in(s_ret), .mem_addr(s_addr), .mem_we(s_we), .mem_re(s_re),
    .pc_load(s_pcl), .count(s_count), .full(s_full), .empty(s_empty),
    .hwm(s_hwm), .err(s_err), .err_code(s_code)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: occupancy as a stack of stored words, plus sticky error state
  int          depth [2] = '{7, 3};
  int          top   [2] = '{255, 2};
  int          mask  [2] = '{16'hFFFF, 8'hFF};
  int          stk   [2][$];
  int          mhwm  [2];
  bit          merr  [2];
  int          mcode [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      stk[i].delete();
      mhwm[i] = 0; merr[i] = 0; mcode[i] = 0;
    end
  endtask

  task automatic check_state(input int i, input string tag);
    int n;
    n = stk[i].size();
    if (i == 0) begin
      chk({tag, ".count"}, 32'(m_count), 32'(n));
      chk({tag, ".hwm"},   32'(m_hwm),   32'(mhwm[0]));
      chk({tag, ".full"},  32'(m_full),  32'(n == depth[0]));
      chk({tag, ".empty"}, 32'(m_empty), 32'(n == 0));
      chk({tag, ".err"},   32'(m_err),   32'(merr[0]));
      chk({tag, ".code"},  32'(m_code),  32'(mcode[0]));
    end else begin
      chk({tag, ".count"}, 32'(s_count), 32'(n));
      chk({tag, ".hwm"},   32'(s_hwm),   32'(mhwm[1]));
      chk({tag, ".full"},  32'(s_full),  32'(n == depth[1]));
      chk({tag, ".empty"}, 32'(s_empty), 32'(n == 0));
      chk({tag, ".err"},   32'(s_err),   32'(merr[1]));
      chk({tag, ".code"},  32'(s_code),  32'(mcode[1]));
    end
  endtask

  // One clocked operation on instance i; called just after a rising edge
  task automatic step(input int i, input bit v, input int o, input bit clr,
                      input int ret, input string tag);
    int  n, bad, eaddr;
    bit  ewe, ere, epl, grows, shrinks;
    logic [15:0] gaddr;
    logic        gwe, gre, gpl;
    m_valid = 1'b0; m_clr = 1'b0; s_valid = 1'b0; s_clr = 1'b0;
    if (i == 0) begin
      m_valid = v; m_op = 3'(o); m_clr = clr; m_ret = 16'(ret);
    end else begin
      s_valid = v; s_op = 3'(o); s_clr = clr; s_ret = 8'(ret);
    end
    #1;
    n       = stk[i].size();
    grows   = v && (o == 1 || o == 3);
    shrinks = v && (o == 2 || o == 4);
    bad     = 0;
    if (v) begin
      if (o == 1 && n == depth[i]) bad = 3;
      if (o == 2 && n == 0)        bad = 4;
      if (o == 4 && n == 0)        bad = 5;
      if (o == 3 && n == depth[i]) bad = 6;
      if (o >= 6)                  bad = 7;
    end
    ewe   = grows && bad == 0;
    ere   = shrinks && bad == 0;
    epl   = ere && o == 4;
    eaddr = grows ? ((top[i] - n) & mask[i]) :
            shrinks ? ((top[i] + 1 - n) & mask[i]) : mask[i];
    if (i == 0) begin
      gaddr = m_addr; gwe = m_we; gre = m_re; gpl = m_pcl;
    end else begin
      gaddr = 16'(s_addr); gwe = s_we; gre = s_re; gpl = s_pcl;
    end
    chk({tag, ".addr"}, 32'(gaddr), 32'(eaddr));
    chk({tag, ".we"},   32'(gwe),   32'(ewe));
    chk({tag, ".re"},   32'(gre),   32'(ere));
    chk({tag, ".pcl"},  32'(gpl),   32'(epl));
    @(posedge clk);
    if (v && o == 5) begin
      stk[i].delete();
      mhwm[i] = 0;
    end else begin
      if (ewe) stk[i].push_back(ret);
      if (ere) void'(stk[i].pop_back());
      if (stk[i].size() > mhwm[i]) mhwm[i] = stk[i].size();
    end
    if (bad != 0) begin
      if (!merr[i] || clr) mcode[i] = bad;
      merr[i] = 1'b1;
    end else if (clr) begin
      merr[i] = 1'b0; mcode[i] = 0;
    end
    #1;
    check_state(i, tag);
  endtask

  task automatic rand_op(output int o);
    int r;
    r = $urandom_range(0, 99);
    if      (r < 35) o = 1;
    else if (r < 55) o = 2;
    else if (r < 70) o = 3;
    else if (r < 85) o = 4;
    else if (r < 88) o = 5;
    else if (r < 93) o = 0;
    else             o = $urandom_range(6, 7);
  endtask

  initial begin
    int o;
    rst_n = 1'b0;
    m_valid = 1'b1; m_op = 3'd1; m_clr = 1'b0; m_ret = '0;
    s_valid = 1'b1; s_op = 3'd1; s_clr = 1'b0; s_ret = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.we_main",  32'(m_we), 32'(0));
    chk("rst.we_small", 32'(s_we), 32'(0));
    check_state(0, "rst");
    check_state(1, "rst");
    #2 rst_n = 1'b1;
    m_valid = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;

    // seven pushes fill the default stack, then overflow
    for (int k = 0; k < 7; k++) step(0, 1, 1, 0, 16'h1000 + k, "fill");
    step(0, 1, 1, 0, 16'hDEAD, "push_full");
    chk("push_full.code3", 32'(m_code), 32'h03);

    // clear, flush, two entries, then RET
    step(0, 1, 0, 1, 0, "clr");
    step(0, 1, 5, 0, 0, "flush");
    step(0, 1, 1, 0, 16'h0111, "p1");
    step(0, 1, 3, 0, 16'h0222, "call");
    step(0, 1, 4, 0, 0, "ret");
    chk("ret.count1", 32'(m_count), 32'd1);

    // first error wins; clear with simultaneous reserved op captures the new code
    step(0, 1, 5, 0, 0, "flush2");
    step(0, 1, 2, 0, 0, "pop_empty");
    for (int k = 0; k < 7; k++) step(0, 1, 1, 0, k, "refill");
    step(0, 1, 3, 0, 16'hBEEF, "call_full");
    chk("call_full.keep04", 32'(m_code), 32'h04);
    step(0, 1, 7, 1, 0, "clr_bad7");
    chk("clr_bad7.code07", 32'(m_code), 32'h07);

    // FLUSH leaves err intact
    step(0, 1, 5, 0, 0, "flush3");
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, k, "five");
    step(0, 1, 5, 0, 0, "flush_err");
    chk("flush_err.err_kept", 32'(m_err), 32'd1);

    // async reset in the middle of a PUSH cycle
    step(0, 1, 1, 0, 1, "pre_rst");
    m_valid = 1'b1; m_op = 3'd1;
    #2;
    chk("mid.we_before", 32'(m_we), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid.we", 32'(m_we), 32'd0);
    check_state(0, "mid");
    @(posedge clk); #2;
    rst_n = 1'b1;
    m_valid = 1'b0;
    @(posedge clk); #1;

    // small instance: 3 pushes at 02,01,00 then POP at 00
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0, k, "sm_push");
    step(1, 1, 2, 0, 0, "sm_pop");
    step(1, 1, 5, 0, 0, "sm_flush");

    // randomized traffic on both instances
    for (int k = 0; k < 400; k++) begin
      rand_op(o);
      step(k % 2, ($urandom_range(0, 9) != 0), o, ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 65535)), (k % 2 == 0) ? "rnd_m" : "rnd_s");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 7, maximum number of stack entries (1..255).
REQ-002 SHALL have parameter AW, default 16, memory address width.
REQ-003 SHALL have parameter TOP, default 16'h00FF, address of first stack slot; stack grows downward.
REQ-004 SHALL derive local constant CW = clog2(DEPTH+1), the count width (3 at default).
REQ-005 SHALL have ports, one clock, reset asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- op_valid  in  1  operation request this cycle.
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 FLUSH, 6-7 reserved.
- err_clr  in  1  clears sticky error.
- ret_in  in  AW  return address supplied with CALL.
- mem_addr  out  AW  data-memory address for current op (combinational).
- mem_we  out  1  write strobe (PUSH, CALL accepted).
- mem_re  out  1  read strobe (POP, RET accepted).
- pc_load  out  1  load PC from memory (RET accepted).
- count  out  CW  current occupancy (registered).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- hwm  out  CW  high-water mark of count since reset/FLUSH.
- err  out  1  sticky error flag.
- err_code  out  8  code of first error since clear.

Function
REQ-006 SHALL accept an op when op_valid=1 and op is not an error case; acceptance is single-cycle, no back-pressure.
REQ-007 SHALL drive mem_addr = TOP - count for PUSH/CALL and TOP + 1 - count for POP/RET, computed in AW bits, modulo 2^AW; otherwise mem_addr = all ones.
REQ-008 SHALL increment count on the clock edge after an accepted PUSH/CALL and decrement after an accepted POP/RET.
REQ-009 SHALL treat PUSH when full as error code 8'h03, POP when empty as 8'h04, RET when empty as 8'h05, CALL when full as 8'h06, reserved op as 8'h07.
REQ-010 SHALL, on an error case, assert no strobe, leave count unchanged, set err on the next edge, and capture err_code only if err was 0.
REQ-011 SHALL keep err and err_code until err_clr=1; err_clr and a new error in the same cycle SHALL leave err=1 with the new code.
REQ-012 SHALL assert pc_load with mem_re only for accepted RET; CALL SHALL present ret_in as the write data path select (mem_we=1, mem_addr per REQ-007).
REQ-013 SHALL on FLUSH set count=0 and hwm=0 on the next edge, no strobes, err unaffected.
REQ-014 SHALL update hwm to max(hwm, next count) every edge.
REQ-015 SHALL ignore op when op_valid=0 (all strobes 0, state held).

Reset
REQ-016 SHALL on rst_n=0 asynchronously set count=0, hwm=0, err=0, err_code=8'h00; strobes are 0 while in reset.
REQ-017 SHALL discard any op in the cycle rst_n deasserts only if rst_n is low at the sampling edge.

Structure
REQ-018 SHALL place op encodings and error-code constants in the shared package stack_pkg, reused by the instruction decoders.
REQ-019 SHALL be a single module; no sub-module instances.

Verification
REQ-020 Reset then 7 PUSH -> mem_addr 00FF,00FE..00F9, count 7, full=1, hwm=7, err=0.
REQ-021 8th PUSH at full -> mem_we=0, count stays 7, err=1, err_code 03.
REQ-022 From count 2, RET -> mem_addr 00FE, mem_re=1, pc_load=1, count 1 next edge.
REQ-023 POP at empty, then CALL when full without err_clr -> err_code stays 04; err_clr with simultaneous bad op 7 -> err=1, err_code 07.
REQ-024 count 5, FLUSH -> count 0, hwm 0, err unchanged; rst_n low mid-PUSH -> count 0 immediately, no mem_we.
REQ-025 DEPTH=3, TOP=0x0002, AW=8: 3 PUSH -> addrs 02,01,00; POP -> addr 00; count width 2.
